// File: rtl/kfps2kb_command_sequencer.sv
//------------------------------------------------------------------------------
// Module      : kfps2kb_command_sequencer
// Description : PS/2 host-to-keyboard command engine (reset FF / LED ED+state),
//               open-drain line drive, ACK/RESEND/timeout handling.
//               Optional resend retries: define KFPS2KB_CMD_RETRY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module kfps2kb_command_sequencer #(
  parameter logic [15:0] INHIBIT_TIME = 16'd1000,
  parameter logic [19:0] OVER_TIME    = 20'd200000,
  parameter logic [1:0]  RETRY_LIMIT  = 2'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       reset_request,
  input  logic       led_request,
  input  logic [2:0] led_state,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_TX        = 3'd2,
    S_TX_ACK    = 3'd3,
    S_WAIT_RESP = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [1:0]  c_kind_reset   = 2'd0;
  localparam logic [1:0]  c_kind_ed      = 2'd1;
  localparam logic [1:0]  c_kind_led     = 2'd2;
  localparam logic [19:0] c_inhibit_last = {4'd0, INHIBIT_TIME} - 20'd1;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_clk_meta, r_clk_sync, r_clk_last;
  logic        r_dat_meta, r_dat_sync;
  logic        r_pend_reset, r_pend_led;
  logic [1:0]  r_kind;
  logic [7:0]  r_shift;
  logic [2:0]  r_led_latched;
  logic [3:0]  r_bit_cnt;
  logic [19:0] r_count;
  logic        r_data_oe;
  logic        r_error;
  logic        w_fall;
  logic        w_timeout;
  logic        w_accept;
  logic        w_ack_ok;
  logic        w_fail;
  logic        w_can_retry;
  logic        w_tx_bit;
  logic        w_pending;

  assign w_fall    = r_clk_last & ~r_clk_sync;
  assign w_timeout = (r_count == OVER_TIME);
  assign w_pending = r_pend_reset | r_pend_led;

  always_comb begin
    w_tx_bit = 1'b1;
    if (r_bit_cnt < 4'd8)
      w_tx_bit = r_shift[r_bit_cnt[2:0]];
    else if (r_bit_cnt == 4'd8)
      w_tx_bit = ~^r_shift;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ack_ok     = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_accept     = 1'b1;
          w_next_state = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_count == c_inhibit_last)
          w_next_state = S_TX;
      end
      S_TX: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9)
            w_next_state = S_TX_ACK;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end
      end
      S_TX_ACK: begin
        if (w_fall) begin
          if (!r_dat_sync)
            w_next_state = S_WAIT_RESP;
          else
            w_fail = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid && rx_byte == 8'hFA) begin
          w_ack_ok     = 1'b1;
          w_next_state = (r_kind == c_kind_ed) ? S_INHIBIT : S_DONE;
        end else if (rx_valid && rx_byte == 8'hFE) begin
          w_fail = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERROR: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_fail)
      w_next_state = w_can_retry ? S_INHIBIT : S_ERROR;
  end

`ifdef KFPS2KB_CMD_RETRY_EN
  logic [1:0] r_retry;

  assign w_can_retry = (r_retry != RETRY_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_retry <= 2'd0;
    else if (w_accept || w_ack_ok)
      r_retry <= 2'd0;
    else if (w_fail && w_can_retry)
      r_retry <= r_retry + 2'd1;
  end
`else
  logic w_unused_retry_limit;

  assign w_unused_retry_limit = |RETRY_LIMIT;
  assign w_can_retry          = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Sync flops idle high like the bus, so leaving reset never fakes a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_last <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= device_clock;
      r_clk_sync <= r_clk_meta;
      r_clk_last <= r_clk_sync;
      r_dat_meta <= device_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_reset  <= 1'b0;
      r_pend_led    <= 1'b0;
      r_kind        <= c_kind_reset;
      r_shift       <= 8'h00;
      r_led_latched <= 3'd0;
      r_bit_cnt     <= 4'd0;
      r_count       <= 20'd0;
      r_data_oe     <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // Our own inhibit pulls the clock low; that edge must not restart the inhibit count.
      if (w_next_state != r_state || (w_fall && r_state != S_INHIBIT))
        r_count <= 20'd0;
      else if (~&r_count)
        r_count <= r_count + 20'd1;

      if (w_accept) begin
        r_kind  <= r_pend_reset ? c_kind_reset : c_kind_ed;
        r_shift <= r_pend_reset ? 8'hFF : 8'hED;
        if (!r_pend_reset)
          r_led_latched <= led_state;
      end else if (w_ack_ok && r_kind == c_kind_ed) begin
        r_kind  <= c_kind_led;
        r_shift <= {5'b00000, r_led_latched};
      end

      if (r_state != S_TX && w_next_state == S_TX) begin
        r_bit_cnt <= 4'd0;
        r_data_oe <= 1'b1;
      end else if (r_state == S_TX && w_fall) begin
        if (r_bit_cnt != 4'd9)
          r_bit_cnt <= r_bit_cnt + 4'd1;
        r_data_oe <= ~w_tx_bit;
      end

      if (w_accept)
        r_error <= 1'b0;
      else if (w_next_state == S_ERROR)
        r_error <= 1'b1;

      if (w_accept) begin
        if (r_pend_reset)
          r_pend_reset <= 1'b0;
        else
          r_pend_led <= 1'b0;
      end
      if (reset_request)
        r_pend_reset <= 1'b1;
      if (led_request)
        r_pend_led <= 1'b1;
    end
  end

  assign device_clock_oe = (r_state == S_INHIBIT);
  assign device_data_oe  = r_data_oe & (r_state == S_TX);
  assign done            = (r_state == S_DONE);
  assign error           = r_error;
  // Busy also covers the DONE/IDLE hop when a queued command is about to start.
  assign busy            = (r_state inside {S_INHIBIT, S_TX, S_TX_ACK, S_WAIT_RESP}) |
                           ((r_state == S_IDLE || r_state == S_DONE) & w_pending);

endmodule

`default_nettype wire
